// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared types, constants and address decode helper for the
//                Harvard CPU data-port responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } mem_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // True when addr falls inside the aligned window of 2^aw words at base.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          aw);
        logic [31:0] span;
        span = WORD_BYTES << aw;
        return (addr & ~(span - 32'd1)) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_sync_ram.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sync_ram
//  Description : Single-port word-wide RAM, synchronous write and read.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_sync_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    // Read output only moves on a read, so it holds between loads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mips_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_data_mem_responder
//  Description : Data-port responder: serves CPU loads/stores from a sync RAM,
//                stalling one cycle per load to cover the RAM read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          data_address,
    input  logic                 data_read,
    input  logic                 data_write,
    input  logic [31:0]          data_writedata,
    output logic [31:0]          data_readdata,
    output logic                 stall,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    mem_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                 err_q, err_d;
    logic                 valid_q, valid_d;
    logic                 oor_q, oor_d;

    logic                  in_range;
    logic                  misaligned;
    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_rdata;

    assign in_range   = in_window(data_address, BASE_ADDR, ADDR_WIDTH);
    assign misaligned = (data_address[1:0] != 2'b00);
    assign ram_addr   = data_address[ADDR_WIDTH+1:2];

    always_comb begin
        state_d    = state_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        valid_d    = valid_q;
        oor_d      = oor_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read; the read is dropped.
                if (data_write) begin
                    if (in_range) begin
                        ram_we = 1'b1;
                        if (wr_count_q != '1) begin
                            wr_count_d = wr_count_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (data_read) begin
                        err_d = 1'b1;
                    end
                end else if (data_read) begin
                    ram_re  = in_range;
                    oor_d   = ~in_range;
                    valid_d = 1'b1;
                    state_d = RESP;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rd_count_q != '1) begin
                    rd_count_d = rd_count_q + CNT_WIDTH'(1);
                end
                if (data_write) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((data_read || data_write) && misaligned) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            oor_q      <= oor_d;
        end
    end

    mips_sync_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & ~reset),
        .re    (ram_re & ~reset),
        .addr  (ram_addr),
        .wdata (data_writedata),
        .rdata (ram_rdata)
    );

    // Stall is decoded from the request strobes only, never from address/data.
    assign stall         = (state_q == IDLE) && data_read && !data_write;
    assign data_readdata = (valid_q && !oor_q) ? ram_rdata : 32'd0;
    assign err           = err_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_data_mem_responder
//  Description : Self-checking bench with a load-data scoreboard and a
//                reference memory/counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_data_mem_responder;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      data_address;
    logic             data_read;
    logic             data_write;
    logic [31:0]      data_writedata;
    logic [31:0]      data_readdata;
    logic             stall;
    logic             err;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    mips_data_mem_responder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'h0000_1000),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .stall          (stall),
        .err            (err),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [0:1023];
    logic [31:0] exp_q [$];
    int          rd_exp;
    int          wr_exp;
    logic        err_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic win(input logic [31:0] a);
        return (a & ~32'h0000_0FFF) == 32'h0000_1000;
    endfunction

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        data_read      = r;
        data_write     = w;
        data_address   = a;
        data_writedata = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_rd_count"}, 32'(rd_count), 32'(rd_exp));
        check({tag, "_wr_count"}, 32'(wr_count), 32'(wr_exp));
        check({tag, "_err"},      32'(err),      32'(err_exp));
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
        check("st_stall", 32'(stall), 32'd0);
        if (win(a)) begin
            model_mem[a[11:2]] = d;
            if (wr_exp < CNT_MAX) wr_exp++;
        end else begin
            err_exp = 1'b1;
        end
        if (a[1:0] != 2'b00) err_exp = 1'b1;
    endtask

    task automatic load(input logic [31:0] a);
        drive(1'b1, 1'b0, a, 32'd0);
        check("ld_stall", 32'(stall), 32'd1);
        exp_q.push_back(win(a) ? model_mem[a[11:2]] : 32'd0);
        if (!win(a) || a[1:0] != 2'b00) err_exp = 1'b1;
        drive(1'b1, 1'b0, a, 32'd0);
        check("resp_stall", 32'(stall), 32'd0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            check("resp_data", data_readdata, exp_q.pop_front());
        end
        if (rd_exp < CNT_MAX) rd_exp++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        idle();
        @(negedge clk);
        reset   = 1'b0;
        rd_exp  = 0;
        wr_exp  = 0;
        err_exp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        data_read = 1'b0;
        data_write = 1'b0;
        data_address = 32'd0;
        data_writedata = 32'd0;
        do_reset();

        repeat (5) idle();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", data_readdata, 32'd0);
        check_regs("rst");

        // store then immediate load of the same word
        store(32'h0000_1010, 32'hDEAD_BEEF);
        load(32'h0000_1010);
        idle();
        check("hold_rdata", data_readdata, 32'hDEAD_BEEF);
        check_regs("st_ld");

        // preload then four back-to-back loads
        store(32'h0000_1000, 32'd1);
        store(32'h0000_1004, 32'd2);
        store(32'h0000_1008, 32'd3);
        store(32'h0000_100C, 32'd4);
        store(32'h0000_13FC, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) load(32'h0000_1000 + 32'(4 * i));
        idle();
        check_regs("b2b");

        // simultaneous read and write: write only, no stall
        drive(1'b1, 1'b1, 32'h0000_1004, 32'h1234_5678);
        check("rw_stall", 32'(stall), 32'd0);
        model_mem[1] = 32'h1234_5678;
        if (wr_exp < CNT_MAX) wr_exp++;
        err_exp = 1'b1;
        idle();
        check_regs("rw");
        load(32'h0000_1004);

        // store attempted during RESP is ignored
        drive(1'b1, 1'b0, 32'h0000_1008, 32'd0);
        exp_q.push_back(model_mem[2]);
        drive(1'b1, 1'b1, 32'h0000_1008, 32'hBAD0_BAD0);
        check("rsp_wr_data", data_readdata, exp_q.pop_front());
        if (rd_exp < CNT_MAX) rd_exp++;
        idle();
        check_regs("rsp_wr");
        load(32'h0000_1008);

        // reset during RESP drops the load
        drive(1'b1, 1'b0, 32'h0000_1000, 32'd0);
        check("rr_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        rd_exp = 0; wr_exp = 0; err_exp = 1'b0;
        idle();
        check("rr_stall2", 32'(stall), 32'd0);
        check("rr_rdata", data_readdata, 32'd0);
        check_regs("rr");

        // misaligned load ignores byte offset but flags err
        load(32'h0000_1011);
        idle();
        check_regs("misal");

        // out-of-range accesses
        do_reset();
        load(32'h0000_0FFC);
        repeat (3) idle();
        check_regs("oor_ld");
        store(32'h0000_2000, 32'hFFFF_FFFF);
        idle();
        check_regs("oor_st");
        load(32'h0000_1000);

        // counter saturation
        for (int i = 0; i < CNT_MAX + 3; i++) store(32'h0000_1100 + 32'(4 * i), 32'(i));
        for (int i = 0; i < CNT_MAX + 3; i++) load(32'h0000_1100 + 32'(4 * i));
        idle();
        check_regs("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
